// File: rtl/cm_pipe_adder_if.sv
// rtl/cm_pipe_adder_if.sv - operand and result stream bundle for cm_pipe_adder
interface cm_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/cm_pipe_adder.sv
// rtl/cm_pipe_adder.sv - pipelined ripple-carry adder/subtractor, SEG bits per stage
module cm_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cm_pipe_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("cm_pipe_adder: WIDTH must be a nonzero multiple of SEG");
    end

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is A + ~B + ~borrow, so both modes share one carry chain.
    assign b_eff        = bus.in_b ^ {WIDTH{bus.in_sub}};
    assign c_eff        = bus.in_cin ^ bus.in_sub;
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;
    assign accept       = bus.in_valid & adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int SW = (k + 1) * SEG;

        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic           seg_c;
        logic           vin;
        logic [SEG:0]   seg_r;
        logic [SW-1:0]  sum_d;
        logic           vq;
        logic           cq;
        logic [SW-1:0]  sq;

        if (k == 0) begin : g_head
            assign seg_a = bus.in_a[SEG-1:0];
            assign seg_b = b_eff[SEG-1:0];
            assign seg_c = c_eff;
            assign vin   = accept;
            assign sum_d = seg_r[SEG-1:0];
        end else begin : g_body
            assign seg_a = g_st[k-1].g_skew.aq[SEG-1:0];
            assign seg_b = g_st[k-1].g_skew.bq[SEG-1:0];
            assign seg_c = g_st[k-1].cq;
            assign vin   = g_st[k-1].vq;
            assign sum_d = {seg_r[SEG-1:0], g_st[k-1].sq};
        end

        assign seg_r = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_c};

        // Data only loads with a live beat so the output holds its last result across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vq <= 1'b0;
                cq <= 1'b0;
                sq <= '0;
            end else if (adv) begin
                vq <= vin;
                if (vin) begin
                    cq <= seg_r[SEG];
                    sq <= sum_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_skew
            localparam int HW = WIDTH - SW;

            logic [HW-1:0] a_d;
            logic [HW-1:0] b_d;
            logic [HW-1:0] aq;
            logic [HW-1:0] bq;

            if (k == 0) begin : g_src_in
                assign a_d = bus.in_a[WIDTH-1:SEG];
                assign b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign a_d = g_st[k-1].g_skew.aq[WIDTH-k*SEG-1:SEG];
                assign b_d = g_st[k-1].g_skew.bq[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    aq <= '0;
                    bq <= '0;
                end else if (adv && vin) begin
                    aq <= a_d;
                    bq <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic msb_cin;
            logic oq;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign msb_cin = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_r[SEG-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    oq <= 1'b0;
                end else if (adv && vin) begin
                    oq <= msb_cin ^ seg_r[SEG];
                end
            end
        end
    end

    assign bus.out_valid = g_st[STAGES-1].vq;
    assign bus.out_sum   = g_st[STAGES-1].sq;
    assign bus.out_cout  = g_st[STAGES-1].cq;
    assign bus.out_ovf   = g_st[STAGES-1].g_tail.oq;
endmodule

// File: doc/cm_pipe_adder.md
Name: cm_pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; generalises the 2-bit carry-in adder cell of the lgsynth91 family to WIDTH bits.
- The carry chain is split into WIDTH/SEG registered segments.
- Valid/ready handshake on input and output.
- Serves as a sequential benchmark block and as a reference datapath for the arithmetic test suite.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 1.
- SEG, 4, bits per pipeline segment; WIDTH % SEG == 0, else elaboration error.
- STAGES, WIDTH/SEG, derived (localparam); pipeline depth = latency in cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in (add) / borrow-in (sub)
- in_sub  input  1  0: A+B+cin; 1: A-B-cin
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result, modulo 2^WIDTH
- out_cout  output  1  raw carry out of MSB (sub: 1 = no borrow)
- out_ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: asserting rst_n low immediately clears all stage valid bits and all data/carry registers. out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 from the first cycle after release.
- Effective operands: B' = in_sub ? ~in_b : in_b; c0 = in_sub ? ~in_cin : in_cin. The result is A + B' + c0 for both modes.
- Global advance: adv = ~out_valid | out_ready; in_ready = adv (purely combinational, no dependence on in_valid).
- Accept on in_valid & in_ready.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and B' with the carry registered from stage k-1 (c0 for stage 0).
- Not-yet-used upper operand bits travel in skew registers; completed lower sum bits travel in de-skew registers.
- All stage registers, including valid, load only when adv=1. When adv=0 all stages hold, including bubbles (no bubble collapsing).
- Latency: an accepted beat appears on out_* exactly STAGES cycles later, provided adv stays 1. Each stalled cycle adds one cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Stage valid bit = registered (in_valid & in_ready) for stage 0, else the previous stage's valid. out_valid = last-stage valid.
- out_sum, out_cout and out_ovf are registered and stable while out_valid & ~out_ready.
- out_ovf = carry into MSB XOR carry out of MSB.
- Simultaneous accept and emit in one cycle is legal, and pipeline occupancy is unchanged. Back-to-back beats must not alias.
- When out_valid=0, out_* hold the last emitted values. They are not zeroed.
- Reset mid-operation discards all in-flight beats. There is no partial output after release.
- STAGES=1 degenerates to a single-register adder with latency 1.
- WIDTH=2, SEG=1, in_sub=0 must reproduce the 2-bit cell: {out_cout,out_sum} = {in_a[1],in_a[0]} + {in_b[1],in_b[0]} + in_cin.

Test Plan:
1. WIDTH=16, SEG=4, out_ready=1: A=0x00FF, B=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0100, cout=0, ovf=0.
2. Carry across all segments: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 -> sum=0x8000, ovf=1, cout=0.
3. Subtract: A=0x0005, B=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0. A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
4. Backpressure: stream 8 random beats back-to-back and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, out_* stable, all 8 results in order, matching the model, none lost or duplicated.
5. Reset mid-flight: accept 3 beats, pull rst_n low for 1 cycle before any emerges -> out_valid stays 0 for 5+ cycles afterwards, out_sum=0.
6. WIDTH=2, SEG=1: sweep all 32 combinations of (a, b, cin) -> {out_cout,out_sum} equals the arithmetic sum; latency 2.
